// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI mode-0 frame receiver.
package spi_frame_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int BITCNT_W   = 5;
    localparam int ERRCNT_W   = 4;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } state_t;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a delay flop
// that turns the synchronised level into single-cycle rise/fall strobes.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   delay_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= {SYNC_STAGES{RST_VAL}};
            delay_reg <= RST_VAL;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], din};
            delay_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  =  level & ~delay_reg;
    assign fall  = ~level &  delay_reg;

endmodule

// File: rtl/spi_frame_rx.sv
// SPI mode-0 receiver: synchronises the pins, deserialises one 16-bit frame per
// chip-select window and reports good frames (fields + pulse) or length errors.
module spi_frame_rx
    import spi_frame_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              copi,
    output logic              frame_valid,
    output logic              frame_rw,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [BITCNT_W-1:0] CNT_FULL = BITCNT_W'(FRAME_BITS);
    localparam logic [BITCNT_W-1:0] CNT_SAT  = BITCNT_W'(FRAME_BITS + 1);
    localparam int                  ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]    ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic cs_level, cs_rise, cs_fall;
    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic copi_level, copi_rise_unused, copi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .level(copi_level), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t                  state_reg, state_next;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [BITCNT_W-1:0]     bit_cnt_reg;
    logic [ARM_W-1:0]        arm_cnt_reg;
    logic [ERRCNT_W-1:0]     err_cnt_reg;
    logic                    valid_reg, err_reg, rw_reg;
    logic [ADDR_W-1:0]       addr_reg;
    logic [DATA_W-1:0]       data_reg;
    logic                    flushed;
    logic                    clear_frame, shift_en, load_en, err_en;

    // The cs_n chain resets high, so its level means nothing until real pin
    // samples have reached the delay flop; ARM waits that long before trusting it.
    assign flushed = (arm_cnt_reg == ARM_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ARM;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARM:     if (flushed && cs_level) state_next = IDLE;
            IDLE:    if (cs_fall)             state_next = SHIFT;
            SHIFT:   if (cs_rise)             state_next = IDLE;
            default:                          state_next = ARM;
        endcase
    end

    // A cs_n rise takes priority over an sclk rise in the same cycle.
    always_comb begin
        clear_frame = 1'b0;
        shift_en    = 1'b0;
        load_en     = 1'b0;
        err_en      = 1'b0;
        case (state_reg)
            IDLE:  clear_frame = cs_fall;
            SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_reg == CNT_FULL) load_en = 1'b1;
                    else                         err_en  = 1'b1;
                end else if (sclk_rise) begin
                    shift_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt_reg <= '0;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
        end else begin
            if (!flushed) arm_cnt_reg <= arm_cnt_reg + 1'b1;
            if (clear_frame) begin
                shift_reg   <= '0;
                bit_cnt_reg <= '0;
            end else if (shift_en) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_level};
                if (bit_cnt_reg != CNT_SAT) bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            rw_reg      <= 1'b0;
            addr_reg    <= '0;
            data_reg    <= '0;
            err_cnt_reg <= '0;
        end else begin
            valid_reg <= load_en;
            err_reg   <= err_en;
            if (load_en) begin
                rw_reg   <= shift_reg[FRAME_BITS-1];
                addr_reg <= shift_reg[FRAME_BITS-2:DATA_W];
                data_reg <= shift_reg[DATA_W-1:0];
            end
            if (err_en && (err_cnt_reg != {ERRCNT_W{1'b1}})) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    assign frame_valid = valid_reg;
    assign frame_err   = err_reg;
    assign frame_rw    = rw_reg;
    assign frame_addr  = addr_reg;
    assign frame_data  = data_reg;
    assign err_count   = err_cnt_reg;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: table of frames plus hand sequences for
// noise, reset mid-frame, error-count saturation and back-to-back frames.
module tb_spi_frame_rx;

    localparam int SYNC = 2;
    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;

    logic       clk = 1'b0;
    logic       rst_n, sclk, cs_n, copi;
    logic       frame_valid, frame_rw, frame_err;
    logic [6:0] frame_addr;
    logic [7:0] frame_data;
    logic [3:0] err_count;

    int errors = 0;
    int checks = 0;
    int tot_v  = 0;
    int tot_e  = 0;

    logic       exp_rw;
    logic [6:0] exp_addr;
    logic [7:0] exp_data;
    int         exp_ecnt;

    typedef struct {
        logic [31:0] bits;
        int          nbits;
        int          kind;
        logic        rw;
        logic [6:0]  addr;
        logic [7:0]  data;
    } vec_t;

    vec_t vecs[3];

    spi_frame_rx #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .copi(copi),
        .frame_valid(frame_valid), .frame_rw(frame_rw), .frame_addr(frame_addr),
        .frame_data(frame_data), .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) tot_v++;
        if (frame_err)   tot_e++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            copi = bits[i];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        cs_n = 1'b0;
        wait_clk(4);
    endtask

    // Raises cs_n and watches 'win' cycles for the result pulse.
    task automatic end_frame(input int kind, input logic rw, input logic [6:0] addr,
                             input logic [7:0] data, input int win, input string tag);
        int vcnt = 0, ecnt = 0, both = 0, pos = 0;
        wait_clk(2);
        cs_n = 1'b1;
        for (int k = 1; k <= win; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) begin vcnt++; if (kind == K_VALID) pos = k; end
            if (frame_err)   begin ecnt++; if (kind == K_ERR)   pos = k; end
            if (frame_valid && frame_err) both++;
        end
        if (kind == K_VALID) begin
            exp_rw = rw; exp_addr = addr; exp_data = data;
        end
        if (kind == K_ERR && exp_ecnt < 15) exp_ecnt++;
        check({tag, " valid_pulses"}, vcnt, (kind == K_VALID) ? 1 : 0);
        check({tag, " err_pulses"}, ecnt, (kind == K_ERR) ? 1 : 0);
        if (kind != K_NONE) check({tag, " pulse_latency"}, pos, SYNC + 1);
        check({tag, " both_high"}, both, 0);
        check({tag, " err_count"}, err_count, exp_ecnt);
        check({tag, " rw"}, frame_rw, exp_rw);
        check({tag, " addr"}, frame_addr, exp_addr);
        check({tag, " data"}, frame_data, exp_data);
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits, input int kind,
                              input logic rw, input logic [6:0] addr, input logic [7:0] data,
                              input int win, input string tag);
        start_frame();
        if (nbits > 0) shift_bits(bits, nbits - 1, 0);
        end_frame(kind, rw, addr, data, win, tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " valid"}, frame_valid, 0);
        check({tag, " err"}, frame_err, 0);
        check({tag, " rw"}, frame_rw, 0);
        check({tag, " addr"}, frame_addr, 0);
        check({tag, " data"}, frame_data, 0);
        check({tag, " err_count"}, err_count, 0);
    endtask

    initial begin
        int v0, e0;
        vecs[0] = '{32'h0000_84A5, 16, K_VALID, 1'b1, 7'h04, 8'hA5};
        vecs[1] = '{32'h0000_7FFF, 15, K_ERR,   1'b0, 7'h00, 8'h00};
        vecs[2] = '{32'h0001_5AC3, 17, K_ERR,   1'b0, 7'h00, 8'h00};

        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; copi = 1'b0;
        exp_rw = 1'b0; exp_addr = '0; exp_data = '0; exp_ecnt = 0;
        wait_clk(3);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(8);

        for (int i = 0; i < 3; i++) begin
            send_frame(vecs[i].bits, vecs[i].nbits, vecs[i].kind, vecs[i].rw,
                       vecs[i].addr, vecs[i].data, 8, $sformatf("vec%0d", i));
            wait_clk(4);
        end

        // sclk activity with cs_n high must not be captured
        v0 = tot_v; e0 = tot_e;
        for (int i = 0; i < 20; i++) begin
            copi = i[0];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(6);
        check("noise valid_pulses", tot_v - v0, 0);
        check("noise err_pulses", tot_e - e0, 0);
        send_frame(32'h0233, 16, K_VALID, 1'b0, 7'h02, 8'h33, 8, "after_noise");
        wait_clk(4);

        // Reset in the middle of a frame, released while cs_n is still low
        start_frame();
        shift_bits(32'hC3C3, 15, 8);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_rw = 1'b0; exp_addr = '0; exp_data = '0; exp_ecnt = 0;
        check_reset_outputs("midreset");
        wait_clk(3);
        rst_n = 1'b1;
        shift_bits(32'hC3C3, 7, 0);
        end_frame(K_NONE, 1'b0, 7'h00, 8'h00, 8, "aborted");
        wait_clk(8);
        send_frame(32'h8111, 16, K_VALID, 1'b1, 7'h01, 8'h11, 8, "after_reset");
        wait_clk(4);

        // 17 empty frames at minimum cs_n high time; counter saturates at 15
        for (int i = 0; i < 17; i++) begin
            send_frame(32'h0, 0, K_ERR, 1'b0, 7'h00, 8'h00, SYNC + 2, $sformatf("empty%0d", i));
        end
        check("saturated err_count", err_count, 15);
        wait_clk(4);

        // Two good frames separated by the minimum cs_n high gap
        send_frame(32'h1234, 16, K_VALID, 1'b0, 7'h12, 8'h34, SYNC + 2, "b2b_a");
        send_frame(32'hFE01, 16, K_VALID, 1'b1, 7'h7E, 8'h01, 8, "b2b_b");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
